// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
//   state_e    : sequencer FSM state (2-bit, encoding visible on seq_state)
//   MAX_STAGES : upper bound on the number of staged reset outputs
//   SEQ_CNT_W  : width of the optional completed-sequence counter
//   IDX_W      : width of the stage index register
package rst_seq_pkg;

  localparam int unsigned MAX_STAGES = 8;
  localparam int unsigned SEQ_CNT_W  = 8;
  localparam int unsigned IDX_W      = $clog2(MAX_STAGES);

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StHold    = 2'd1,
    StRelease = 2'd2,
    StDone    = 2'd3
  } state_e;

endpackage

// File: rtl/rst_seq_timer.sv
// Hold-interval timer for the reset sequencer.
//   clk_i  : clock, posedge
//   rst_ni : synchronous active-low reset
//   clr_i  : clear count to zero (wins over en_i)
//   en_i   : advance count by one
//   tc_o   : terminal count, high while count == HOLD_CYCLES-1
module rst_seq_timer #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: releases NUM_STAGES active-low resets in ascending
// order, one per HOLD_CYCLES interval, then flags rst_done. A level-held
// software request in the done state re-runs the whole sequence.
//   clk         : clock, posedge
//   reset       : synchronous active-low reset
//   sw_rst_req  : level request to re-sequence, held until sw_rst_ack
//   sw_rst_ack  : one-cycle pulse, request accepted
//   stage_rst_n : staged active-low resets, bit k released k-th
//   rst_done    : high once every stage has been released
//   seq_state   : current FSM state (state_e encoding)
//   seq_count   : completed sequences, saturating (only with RST_SEQ_STATUS_EN)
// Build option: define RST_SEQ_STATUS_EN to add the seq_count output.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  rst_done,
  output logic [1:0]            seq_state
`ifdef RST_SEQ_STATUS_EN
  ,
  output logic [SEQ_CNT_W-1:0]  seq_count
`endif
);

  state_e                state_q, state_d;
  logic                  settled_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ack_q, ack_d;
  logic                  done_q, done_d;
  logic                  tc;
  logic                  last_stage;
  logic                  accept;

  assign last_stage = (idx_q == IDX_W'(NUM_STAGES - 1));
  assign accept     = (state_q == StDone) && sw_rst_req;

  // Timer sits at zero outside HOLD, so every HOLD entry starts from a clean count.
  rst_seq_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (state_q != StHold),
    .en_i   ((state_q == StHold) && !tc),
    .tc_o   (tc)
  );

  // settled_q keeps ASSERT for one full cycle after reset is first seen high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StAssert;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settled_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAssert:  if (settled_q) state_d = StHold;
      StHold:    if (tc) state_d = StRelease;
      StRelease: state_d = last_stage ? StDone : StHold;
      StDone:    if (sw_rst_req) state_d = StAssert;
      default:   state_d = StAssert;
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    idx_d   = idx_q;
    ack_d   = accept;
    // rst_done follows DONE entry by one cycle and drops on the accepting edge.
    done_d  = (state_q == StDone) && !accept;
    unique case (state_q)
      StAssert: begin
        stage_d = '0;
        idx_d   = '0;
      end
      StRelease: begin
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
          if (idx_q == IDX_W'(k)) stage_d[k] = 1'b1;
        end
        if (!last_stage) idx_d = idx_q + 1'b1;
      end
      StDone: begin
        if (accept) begin
          stage_d = '0;
          idx_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign stage_rst_n = stage_q;
  assign sw_rst_ack  = ack_q;
  assign rst_done    = done_q;
  assign seq_state   = state_q;

`ifdef RST_SEQ_STATUS_EN
  logic [SEQ_CNT_W-1:0] seq_cnt_q;

  // Counts DONE entries: the edge that releases the last stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seq_cnt_q <= '0;
    end else if ((state_q == StRelease) && last_stage && (seq_cnt_q != '1)) begin
      seq_cnt_q <= seq_cnt_q + 1'b1;
    end
  end

  assign seq_count = seq_cnt_q;
`else
  // No sequence counter in this build.
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer (NUM_STAGES=2, HOLD_CYCLES=16).
// A schedule-based reference model predicts every output from the cycle
// at which the current sequence was anchored (reset release or accepted request).
module tb_rst_sequencer;

  localparam int NS       = 2;
  localparam int HC       = 16;
  localparam int P        = HC + 1;      // cycles per stage: hold + release
  localparam int DONE_REL = NS * P + 2;  // rst_done rise, relative to anchor

  logic          clk = 1'b0;
  logic          reset;
  logic          sw_rst_req;
  logic          sw_rst_ack;
  logic [NS-1:0] stage_rst_n;
  logic          rst_done;
  logic [1:0]    seq_state;
`ifdef RST_SEQ_STATUS_EN
  logic [7:0]    seq_count;
`endif

  always #5 clk = ~clk;

  rst_sequencer #(
    .NUM_STAGES  (NS),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_rst_req  (sw_rst_req),
    .sw_rst_ack  (sw_rst_ack),
    .stage_rst_n (stage_rst_n),
    .rst_done    (rst_done),
    .seq_state   (seq_state)
`ifdef RST_SEQ_STATUS_EN
    ,
    .seq_count   (seq_count)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int cyc    = 0;  // posedge number, first edge is 1
  bit m_rst  = 1'b1;
  int anchor = 0;
  bit m_ack  = 1'b0;
  int m_cnt  = 0;

  bit drv_rst = 1'b0;
  bit drv_req = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    cyc++;
    m_ack = 1'b0;
    if (!drv_rst) begin
      m_rst = 1'b1;
    end else if (m_rst) begin
      m_rst  = 1'b0;
      anchor = cyc;
    end else if (drv_req && (cyc - anchor >= DONE_REL)) begin
      anchor = cyc;
      m_ack  = 1'b1;
    end
    if (!drv_rst) m_cnt = 0;
    else if (!m_rst && (cyc - anchor == NS * P + 1) && m_cnt < 255) m_cnt++;
  endtask

  task automatic compare_all();
    logic [NS-1:0] es;
    logic          ed;
    logic [1:0]    est;
    int            r;
    es  = '0;
    ed  = 1'b0;
    est = 2'd0;
    if (!m_rst) begin
      r = cyc - anchor;
      for (int k = 0; k < NS; k++) es[k] = (r >= (k + 1) * P + 1);
      ed = (r >= DONE_REL);
      if (r == 0) est = 2'd0;
      else if (r >= NS * P + 1) est = 2'd3;
      else if ((r - 1) % P == P - 1) est = 2'd2;
      else est = 2'd1;
    end
    check_eq("stage_rst_n", 32'(stage_rst_n), 32'(es));
    check_eq("rst_done", 32'(rst_done), 32'(ed));
    check_eq("sw_rst_ack", 32'(sw_rst_ack), 32'(m_ack));
    check_eq("seq_state", 32'(seq_state), 32'(est));
`ifdef RST_SEQ_STATUS_EN
    check_eq("seq_count", 32'(seq_count), 32'(m_cnt));
`endif
  endtask

  // Drive inputs, let one posedge happen, check on the following negedge.
  task automatic step();
    reset      = drv_rst;
    sw_rst_req = drv_req;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (m_ack) drv_req = 1'b0;  // requester drops once acknowledged
  endtask

  task automatic run_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (!drv_rst) drv_rst = ($urandom_range(0, 2) != 0);
      else drv_rst = ($urandom_range(0, 199) != 0);
      if (!drv_req && $urandom_range(0, 29) == 0) drv_req = 1'b1;
      step();
    end
  endtask

  initial begin
    int t_s0;
    int t_s1;
    int t_dn;
    t_s0 = 0;
    t_s1 = 0;
    t_dn = 0;
    reset      = 1'b0;
    sw_rst_req = 1'b0;

    // Power-on: reset low for edges 5..35, first high sample at 45.
    drv_rst = 1'b0;
    repeat (4) step();
    drv_rst = 1'b1;
    repeat (60) begin
      step();
      // edge time in clock units: posedges at 5, 15, 25, ...
      if (stage_rst_n[0] && t_s0 == 0) t_s0 = 5 + 10 * (cyc - 1);
      if (stage_rst_n[1] && t_s1 == 0) t_s1 = 5 + 10 * (cyc - 1);
      if (rst_done && t_dn == 0) t_dn = 5 + 10 * (cyc - 1);
    end
    check_eq("t_stage0_rise", 32'(t_s0), 32'd225);
    check_eq("t_stage1_rise", 32'(t_s1), 32'd395);
    check_eq("t_done_rise", 32'(t_dn), 32'd405);

    // Software re-sequence from DONE.
    drv_req = 1'b1;
    repeat (45) step();

    // Reset pulse mid-sequence, with stage 0 already released.
    drv_req = 1'b1;
    repeat (20) step();
    drv_rst = 1'b0;
    step();
    drv_rst = 1'b1;
    repeat (45) step();

    // Early request held from well before DONE.
    drv_rst = 1'b0;
    step();
    drv_rst = 1'b1;
    drv_req = 1'b1;
    repeat (80) step();

    // Reset and request collide on one edge.
    drv_rst = 1'b0;
    drv_req = 1'b1;
    step();
    check_eq("collision_ack", 32'(sw_rst_ack), 32'd0);
    check_eq("collision_state", 32'(seq_state), 32'd0);
    drv_rst = 1'b1;
    drv_req = 1'b0;
    repeat (40) step();

    run_random(3000);

`ifdef RST_SEQ_STATUS_EN
    // Keep re-requesting until the sequence counter saturates.
    drv_rst = 1'b0;
    step();
    drv_rst = 1'b1;
    for (int i = 0; i < 300 * (DONE_REL + 1); i++) begin
      drv_req = 1'b1;
      step();
    end
    check_eq("seq_count_sat", 32'(seq_count), 32'd255);
    drv_rst = 1'b0;
    drv_req = 1'b0;
    step();
    check_eq("seq_count_clr", 32'(seq_count), 32'd0);
    drv_rst = 1'b1;
    repeat (40) step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
